jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
- Shares a bank of NFF JK flip-flops among NREQ requesters.
- Each requester asks for one JK operation (hold, reset, set or toggle) on one flip-flop index.
- A round-robin arbiter grants exactly one requester per clock, and the granted operation is applied to the addressed flip-flop.
- Sits between control logic and the JK storage bank. It replaces direct, uncoordinated driving of the j/k inputs.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NFF, 8, number of JK flip-flops in the bank (2..16)
- IDXW, $clog2(NFF), width of a flip-flop index

Ports:
- en  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request; held high until granted
- req_op  input  2*NREQ  op for requester i at bits [2i+1:2i]: 00 hold, 01 reset (j=0,k=1), 10 set (j=1,k=0), 11 toggle (j=1,k=1)
- req_idx  input  IDXW*NREQ  target flop index for requester i at bits [IDXW*i+IDXW-1:IDXW*i]
- gnt  output  NREQ  one-hot combinational grant; all-zero when req is all-zero
- q  output  NFF  flip-flop bank state
- q_bar  output  NFF  always ~q
- done  output  1  registered one-cycle pulse after each transfer
- done_id  output  $clog2(NREQ)  requester index of the last transfer
- done_q  output  1  new value of the flop written by the last transfer

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - q=0, q_bar=all ones
  - round-robin pointer rr=0
  - done=0, done_id=0, done_q=0
- Arbitration (combinational):
  - Search order starts at requester rr and wraps modulo NREQ.
  - The first i with req[i]=1 gets gnt[i]=1.
  - At most one gnt bit is high.
- Transfer: occurs on a rising edge of en where req[i] && gnt[i].
- Flop update on that edge, with f = req_idx of requester i:
  - 00: q[f] unchanged
  - 01: q[f] <= 0
  - 10: q[f] <= 1
  - 11: q[f] <= ~q[f]
  - All other flops keep their value.
- Latency: the new q is visible in the cycle after the transfer edge. done=1, done_id=i and done_q=new q[f] are visible in that same cycle.
- Pointer update: after a transfer, rr <= (i+1) mod NREQ. With no transfer, rr holds.
- done: high for exactly one cycle per transfer. If back-to-back transfers occur, done stays high and done_id/done_q update every cycle.
- Hold op (00): still consumes a grant, advances rr and pulses done, with done_q = current q[f].
- Out-of-range index (req_idx >= NFF when NFF is not a power of two):
  - The transfer completes and the handshake and rr advance normally.
  - No flop changes.
  - done_q = 0.
- Requester handshake: a requester deasserts req in the cycle after it sees gnt. If req stays high, it is treated as a new request.
- Starvation bound: a continuously requesting requester is granted within NREQ cycles.
- Reset asserted mid-operation: any pending transfer is dropped and all state returns to reset values. The first grant after reset release starts search at requester 0.
- q and q_bar are never driven from combinational paths on req.

Decomposition:
- Shared package jk_pkg:
  - op encoding constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11
  - typedef jk_op_t (2 bits)
- Natural sub-module: jk_cell. It is one JK flip-flop with en clock, rst_n, a write-enable and j,k, and outputs q and q_bar. It is instantiated NFF times.
- Arbiter and pointer logic stay in jk_bank_arbiter.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> immediately q=8'h00, q_bar=8'hFF, done=0, gnt=0 with req=0.
- Single-op sequence:
  - Stimulus: requester 0 issues set on idx 3, then toggle on idx 3, then reset on idx 3, then toggle on idx 3.
  - Required: q[3] follows 1,0,0,1 one cycle after each grant; done_id=0 each time; done_q matches q[3].
- Round-robin fairness:
  - Stimulus: all 4 requesters hold req=1 continuously, each toggling its own idx 0..3.
  - Required: grant order is 0,1,2,3,0,1,...; after 8 cycles q[3:0]=4'b0000 with each flop toggled twice.
- Same-flop contention:
  - Stimulus: requester 1 sets idx 5 and requester 2 resets idx 5 in the same cycle, with rr=0.
  - Required: gnt=4'b0010 first, then 4'b0100; final q[5]=0; done_id sequence 1,2.
- Hold op: requester 3 issues op 00 on idx 7 when q[7]=1 -> q unchanged, done=1, done_q=1, rr advances to 0.
- Reset mid-stream:
  - Stimulus: during continuous toggling by requester 2, pulse rst_n low for 3 ns.
  - Required: q=0 and done=0 immediately; after release with req=4'b1111, the first gnt is 4'b0001.

Source files
------------

// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK bank arbiter and its flip-flop cells.
//   jk_op_t : 2-bit JK operation, bit 1 drives j and bit 0 drives k.
// -----------------------------------------------------------------------------
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,  // j=0 k=0 : keep value
        JK_RST  = 2'b01,  // j=0 k=1 : clear
        JK_SET  = 2'b10,  // j=1 k=0 : set
        JK_TGL  = 2'b11   // j=1 k=1 : invert
    } jk_op_t;

endpackage

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
// One JK flip-flop with a write enable. When we is low the cell holds its
// value regardless of j/k, so a j/k pair can be shared by a whole bank.
// Ports:
//   en     in  clock, rising edge
//   rst_n  in  asynchronous active-low reset (q -> 0)
//   we     in  write enable for this cell
//   j, k   in  JK inputs, sampled only when we is high
//   q      out flip-flop state
//   q_bar  out inverse of q
// -----------------------------------------------------------------------------
module jk_cell
    import jk_pkg::*;
(
    input  logic en,
    input  logic rst_n,
    input  logic we,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic q_q;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the design samples pre-edge values, independent of process order.
    always_ff @(posedge en or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else if (we) begin
            case (jk_op_t'({j, k}))
                JK_RST:  q_q <= 1'b0;
                JK_SET:  q_q <= 1'b1;
                JK_TGL:  q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter
// Round-robin arbiter that lets NREQ requesters share a bank of NFF JK
// flip-flops. One request is granted per clock; its op is applied to the
// addressed flop on that edge and reported through done/done_id/done_q in
// the following cycle.
// Ports:
//   en       in  clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   req      in  [NREQ]       request per requester, held until granted
//   req_op   in  [2*NREQ]     op for requester i at [2i+1:2i] (jk_op_t)
//   req_idx  in  [IDXW*NREQ]  flop index for requester i
//   gnt      out [NREQ]       one-hot combinational grant
//   q        out [NFF]        bank state
//   q_bar    out [NFF]        ~q
//   done     out              one-cycle pulse after each transfer
//   done_id  out              requester index of the last transfer
//   done_q   out              new value of the flop written by that transfer
// -----------------------------------------------------------------------------
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IDXW = $clog2(NFF)
) (
    input  logic                     en,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [IDXW*NREQ-1:0]     req_idx,
    output logic [NREQ-1:0]          gnt,
    output logic [NFF-1:0]           q,
    output logic [NFF-1:0]           q_bar,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic                     done_q
);

    localparam int IDW = $clog2(NREQ);

    // Requester index base+off, wrapped modulo NREQ (NREQ need not be 2^n).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s -= NREQ;
        return IDW'(s);
    endfunction

    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  sel;
    logic            xfer;
    jk_op_t          sel_op;
    logic [IDXW-1:0] sel_idx;
    logic            in_range;
    logic            cur_q;
    logic            new_q;
    logic [NFF-1:0]  we;
    logic            done_flag_q;
    logic [IDW-1:0]  done_id_q;
    logic            done_val_q;

    // Round-robin search starting at rr_q; first active request wins.
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt  = '0;
        sel  = '0;
        xfer = 1'b0;
        for (int n = 0; n < NREQ; n++) begin
            if (!xfer && req[rr_index(rr_q, n)]) begin
                gnt[rr_index(rr_q, n)] = 1'b1;
                sel                    = rr_index(rr_q, n);
                xfer                   = 1'b1;
            end
        end
    end

    // Decode the winner's op and target; compute the value it will leave.
    always_comb begin
        sel_op   = jk_op_t'(req_op[2*int'(sel) +: 2]);
        sel_idx  = req_idx[IDXW*int'(sel) +: IDXW];
        // Only meaningful when NFF is not a power of two.
        in_range = ({1'b0, sel_idx} < (IDXW+1)'(NFF));
        cur_q    = 1'b0;
        we       = '0;
        for (int f = 0; f < NFF; f++) begin
            if (sel_idx == IDXW'(f)) begin
                cur_q = q[f];
                we[f] = xfer;
            end
        end
        case (sel_op)
            JK_RST:  new_q = 1'b0;
            JK_SET:  new_q = 1'b1;
            JK_TGL:  new_q = ~cur_q;
            default: new_q = cur_q;
        endcase
        if (!in_range) new_q = 1'b0;
    end

    assign rr_d = xfer ? rr_index(sel, 1) : rr_q;

    // The bank: j/k are shared, only the addressed cell is write-enabled.
    for (genvar f = 0; f < NFF; f++) begin : g_cell
        jk_cell u_cell (
            .en    (en),
            .rst_n (rst_n),
            .we    (we[f]),
            .j     (sel_op[1]),
            .k     (sel_op[0]),
            .q     (q[f]),
            .q_bar (q_bar[f])
        );
    end

    // Pointer and completion status. done_id/done_q keep the last transfer.
    always_ff @(posedge en or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            done_flag_q <= 1'b0;
            done_id_q   <= '0;
            done_val_q  <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            done_flag_q <= xfer;
            if (xfer) begin
                done_id_q  <= sel;
                done_val_q <= new_q;
            end
        end
    end

    assign done    = done_flag_q;
    assign done_id = done_id_q;
    assign done_q  = done_val_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_arbiter
// Directed bench for jk_bank_arbiter. A behavioural model (bit array, integer
// pointer) is compared against every output on each falling clock edge, and
// hand-computed literals pin the expected behaviour of each scenario.
// -----------------------------------------------------------------------------
module tb_jk_bank_arbiter;
    import jk_pkg::*;

    localparam int NREQ = 4;
    localparam int NFF  = 8;
    localparam int IDXW = 3;

    logic                   en = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [2*NREQ-1:0]      req_op = '0;
    logic [IDXW*NREQ-1:0]   req_idx = '0;
    logic [NREQ-1:0]        gnt;
    logic [NFF-1:0]         q;
    logic [NFF-1:0]         q_bar;
    logic                   done;
    logic [1:0]             done_id;
    logic                   done_q;

    jk_bank_arbiter #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
        .en      (en),
        .rst_n   (rst_n),
        .req     (req),
        .req_op  (req_op),
        .req_idx (req_idx),
        .gnt     (gnt),
        .q       (q),
        .q_bar   (q_bar),
        .done    (done),
        .done_id (done_id),
        .done_q  (done_q)
    );

    always #5 en = ~en;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NFF-1:0] m_q = '0;
    int             m_rr = 0;
    logic           m_done = 1'b0;
    int             m_done_id = 0;
    logic           m_done_q = 1'b0;
    int             mg;
    int             mf;
    jk_op_t         mop;

    // Who would be granted now: first requester at or after m_rr, wrapping.
    function automatic int model_grant();
        for (int n = 0; n < NREQ; n++) begin
            if (req[(m_rr + n) % NREQ]) return (m_rr + n) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge en or negedge rst_n) begin
        if (!rst_n) begin
            m_q       = '0;
            m_rr      = 0;
            m_done    = 1'b0;
            m_done_id = 0;
            m_done_q  = 1'b0;
        end else begin
            mg     = model_grant();
            m_done = (mg >= 0);
            if (mg >= 0) begin
                mop = jk_op_t'(req_op[2*mg +: 2]);
                mf  = int'(req_idx[IDXW*mg +: IDXW]);
                if (mf < NFF) begin
                    if (mop == JK_RST)      m_q[mf] = 1'b0;
                    else if (mop == JK_SET) m_q[mf] = 1'b1;
                    else if (mop == JK_TGL) m_q[mf] = ~m_q[mf];
                    m_done_q = m_q[mf];
                end else begin
                    m_done_q = 1'b0;
                end
                m_done_id = mg;
                m_rr      = (mg + 1) % NREQ;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge en) begin
        int             g;
        logic [NFF-1:0] m_qb;
        g    = model_grant();
        m_qb = ~m_q;
        check("gnt",     gnt,     (g < 0) ? 32'd0 : (32'd1 << g));
        check("q",       q,       m_q);
        check("q_bar",   q_bar,   m_qb);
        check("done",    done,    m_done);
        check("done_id", done_id, m_done_id);
        check("done_q",  done_q,  m_done_q);
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input int i, input jk_op_t op, input int idx);
        req[i]                 = 1'b1;
        req_op[2*i +: 2]       = op;
        req_idx[IDXW*i +: IDXW] = IDXW'(idx);
    endtask

    task automatic step();
        @(posedge en);
        #1;
    endtask

    logic [3:0] rr_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    jk_op_t     seq_op [4] = '{JK_SET, JK_TGL, JK_RST, JK_TGL};
    logic       seq_q  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset state with req idle.
        #3;
        check("rst_q",     q,     8'h00);
        check("rst_q_bar", q_bar, 8'hFF);
        check("rst_done",  done,  1'b0);
        check("rst_gnt",   gnt,   4'b0000);
        @(negedge en);
        #1 rst_n = 1'b1;
        step();

        // Round-robin: all four toggle their own flop continuously.
        for (int i = 0; i < NREQ; i++) put(i, JK_TGL, i);
        for (int n = 0; n < 8; n++) begin
            #1 check("rr_order", gnt, rr_exp[n]);
            step();
            if (n == 3) check("rr_half_q", q[3:0], 4'b1111);
        end
        check("rr_final_q", q[3:0], 4'b0000);
        req = '0;

        // Single-op sequence on flop 3 by requester 0.
        for (int n = 0; n < 4; n++) begin
            req = '0;
            put(0, seq_op[n], 3);
            step();
            check("seq_q3",      q[3],    seq_q[n]);
            check("seq_done",    done,    1'b1);
            check("seq_done_id", done_id, 2'd0);
            check("seq_done_q",  done_q,  seq_q[n]);
        end
        req = '0;
        step();
        check("seq_idle_done", done, 1'b0);

        // Hold op: requester 3 sets flop 7, then holds it.
        put(3, JK_SET, 7);
        step();
        req = '0;
        put(3, JK_HOLD, 7);
        #1 check("hold_gnt", gnt, 4'b1000);
        step();
        req = '0;
        check("hold_q",       q,       8'h88);
        check("hold_done",    done,    1'b1);
        check("hold_done_id", done_id, 2'd3);
        check("hold_done_q",  done_q,  1'b1);
        req = '1;
        #1 check("hold_rr0", gnt, 4'b0001);
        req = '0;

        // Same-flop contention on flop 5, pointer at 0.
        put(1, JK_SET, 5);
        put(2, JK_RST, 5);
        #1 check("cont_gnt1", gnt, 4'b0010);
        step();
        req[1] = 1'b0;
        #1 check("cont_gnt2", gnt, 4'b0100);
        check("cont_id1", done_id, 2'd1);
        check("cont_q5a", q[5],    1'b1);
        step();
        req = '0;
        check("cont_id2",   done_id, 2'd2);
        check("cont_q5b",   q[5],    1'b0);
        check("cont_done",  done,    1'b1);

        // Reset mid-stream while requester 2 toggles flop 2.
        put(2, JK_TGL, 2);
        repeat (3) step();
        check("pre_rst_q2", q[2], 1'b1);
        @(negedge en);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_q",     q,     8'h00);
        check("mid_rst_q_bar", q_bar, 8'hFF);
        check("mid_rst_done",  done,  1'b0);
        for (int i = 0; i < NREQ; i++) put(i, JK_TGL, i);
        #1 check("mid_rst_gnt", gnt, 4'b0001);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_id", done_id, 2'd0);
        check("post_rst_q",  q,       8'h01);
        req = '0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
